// File: rtl/cache_controller_if.sv
// Control/status bundle between the cache controller FSM and the cache datapath.
interface cache_internal_if;
    logic miss_recovery_mode;
    logic process_lru_counters;
    logic clear_selected_dirty_bit;
    logic set_selected_dirty_bit;
    logic perform_write;
    logic clear_selected_valid_bit;
    logic finish_new_line_install;
    logic set_hmem_block_address;
    logic use_victim_tag_for_hmem_block_address;
    logic reset_counter;
    logic decrement_counter;
    logic counter_done;
    logic valid_block_match;
    logic valid_dirty_bit;

    modport controller (
        output miss_recovery_mode, process_lru_counters, clear_selected_dirty_bit,
               set_selected_dirty_bit, perform_write, clear_selected_valid_bit,
               finish_new_line_install, set_hmem_block_address,
               use_victim_tag_for_hmem_block_address, reset_counter, decrement_counter,
        input  counter_done, valid_block_match, valid_dirty_bit
    );

    modport datapath (
        input  miss_recovery_mode, process_lru_counters, clear_selected_dirty_bit,
               set_selected_dirty_bit, perform_write, clear_selected_valid_bit,
               finish_new_line_install, set_hmem_block_address,
               use_victim_tag_for_hmem_block_address, reset_counter, decrement_counter,
        output counter_done, valid_block_match, valid_dirty_bit
    );
endinterface

// File: rtl/cache_controller.sv
// Single-level cache control FSM: lookup, dirty writeback, line fill, install and replay,
// with saturating hit/miss/writeback statistics.
module cache_controller #(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_op,
    output logic                  req_fulfilled,
    output logic                  hmem_req_valid,
    output logic                  hmem_op,
    input  logic                  hmem_req_fulfilled,
    cache_internal_if.controller  ctrl,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count,
    output logic [STAT_WIDTH-1:0] wb_count
);

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, INSTALL} state_t;

    state_t state;
    state_t state_next;
    logic   replay;
    logic   hit_event;
    logic   miss_event;
    logic   wb_event;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    always_comb begin
        // NOTE: every output gets a 0 default before the case, so no latch is inferred
        // and any state that does not mention an output leaves it low.
        state_next                                 = state;
        req_fulfilled                              = 1'b0;
        hmem_req_valid                             = 1'b0;
        hmem_op                                    = 1'b0;
        ctrl.miss_recovery_mode                    = 1'b0;
        ctrl.process_lru_counters                  = 1'b0;
        ctrl.clear_selected_dirty_bit              = 1'b0;
        ctrl.set_selected_dirty_bit                = 1'b0;
        ctrl.perform_write                         = 1'b0;
        ctrl.clear_selected_valid_bit              = 1'b0;
        ctrl.finish_new_line_install               = 1'b0;
        ctrl.set_hmem_block_address                = 1'b0;
        ctrl.use_victim_tag_for_hmem_block_address = 1'b0;
        ctrl.reset_counter                         = 1'b0;
        ctrl.decrement_counter                     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) state_next = COMPARE;
            end
            COMPARE: begin
                if (ctrl.valid_block_match) begin
                    req_fulfilled                = 1'b1;
                    ctrl.process_lru_counters    = 1'b1;
                    ctrl.set_selected_dirty_bit  = req_op;
                    ctrl.perform_write           = req_op;
                    state_next                   = IDLE;
                end else begin
                    ctrl.set_hmem_block_address  = 1'b1;
                    ctrl.reset_counter           = 1'b1;
                    ctrl.miss_recovery_mode      = 1'b1;
                    if (ctrl.valid_dirty_bit) begin
                        ctrl.use_victim_tag_for_hmem_block_address = 1'b1;
                        state_next                                 = WRITEBACK;
                    end else begin
                        ctrl.clear_selected_valid_bit = 1'b1;
                        state_next                    = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                ctrl.miss_recovery_mode = 1'b1;
                hmem_req_valid          = 1'b1;
                hmem_op                 = 1'b1;
                if (hmem_req_fulfilled) begin
                    if (ctrl.counter_done) begin
                        // Victim is now clean and invalid; retarget hmem at the missing line.
                        ctrl.clear_selected_dirty_bit = 1'b1;
                        ctrl.clear_selected_valid_bit = 1'b1;
                        ctrl.set_hmem_block_address   = 1'b1;
                        ctrl.reset_counter            = 1'b1;
                        state_next                    = ALLOCATE;
                    end else begin
                        ctrl.decrement_counter = 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                ctrl.miss_recovery_mode = 1'b1;
                hmem_req_valid          = 1'b1;
                if (hmem_req_fulfilled) begin
                    ctrl.perform_write = 1'b1;
                    if (ctrl.counter_done) state_next = INSTALL;
                    else                   ctrl.decrement_counter = 1'b1;
                end
            end
            INSTALL: begin
                ctrl.finish_new_line_install = 1'b1;
                ctrl.miss_recovery_mode      = 1'b1;
                state_next                   = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The replay lookup after INSTALL is bookkeeping, not a new CPU access.
    assign hit_event  = (state == COMPARE) && ctrl.valid_block_match && !replay;
    assign miss_event = (state == COMPARE) && !ctrl.valid_block_match && !replay;
    assign wb_event   = (state == WRITEBACK) && hmem_req_fulfilled && ctrl.counter_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            replay     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (state == INSTALL)
                replay <= 1'b1;
            else if (state == COMPARE && ctrl.valid_block_match)
                replay <= 1'b0;
            if (hit_event)  hit_count  <= sat_inc(hit_count);
            if (miss_event) miss_count <= sat_inc(miss_count);
            if (wb_event)   wb_count   <= sat_inc(wb_count);
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scripted transaction model for cache_controller: each CPU request expands into per-cycle
// stimulus plus the outputs the control rules demand; a 2-bit-stat copy checks saturation.
module tb_cache_controller;

    typedef struct packed {
        logic rv, op, hful, cd, match, dirty;
    } in_t;

    typedef struct packed {
        logic fulfilled, hreq, hop, mrm, lru, clr_dirty, set_dirty, pw,
              clr_valid, finish, set_addr, use_victim, reset_cnt, dec;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
        logic inc_hit, inc_miss, inc_wb;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic hmem_req_fulfilled = 1'b0;
    logic req_fulfilled, hmem_req_valid, hmem_op;
    logic req_fulfilled2, hmem_req_valid2, hmem_op2;
    logic [31:0] hit_count, miss_count, wb_count;
    logic [1:0]  hit_count2, miss_count2, wb_count2;

    cache_internal_if cif ();
    cache_internal_if cif2 ();

    assign cif2.counter_done      = cif.counter_done;
    assign cif2.valid_block_match = cif.valid_block_match;
    assign cif2.valid_dirty_bit   = cif.valid_dirty_bit;

    cache_controller #(.STAT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_fulfilled(req_fulfilled), .hmem_req_valid(hmem_req_valid), .hmem_op(hmem_op),
        .hmem_req_fulfilled(hmem_req_fulfilled), .ctrl(cif.controller),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_controller #(.STAT_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_fulfilled(req_fulfilled2), .hmem_req_valid(hmem_req_valid2), .hmem_op(hmem_op2),
        .hmem_req_fulfilled(hmem_req_fulfilled), .ctrl(cif2.controller),
        .hit_count(hit_count2), .miss_count(miss_count2), .wb_count(wb_count2)
    );

    always #5 clk = ~clk;

    out_t act, act2;
    assign act = {req_fulfilled, hmem_req_valid, hmem_op, cif.miss_recovery_mode,
                  cif.process_lru_counters, cif.clear_selected_dirty_bit,
                  cif.set_selected_dirty_bit, cif.perform_write, cif.clear_selected_valid_bit,
                  cif.finish_new_line_install, cif.set_hmem_block_address,
                  cif.use_victim_tag_for_hmem_block_address, cif.reset_counter,
                  cif.decrement_counter};
    assign act2 = {req_fulfilled2, hmem_req_valid2, hmem_op2, cif2.miss_recovery_mode,
                   cif2.process_lru_counters, cif2.clear_selected_dirty_bit,
                   cif2.set_selected_dirty_bit, cif2.perform_write, cif2.clear_selected_valid_bit,
                   cif2.finish_new_line_install, cif2.set_hmem_block_address,
                   cif2.use_victim_tag_for_hmem_block_address, cif2.reset_counter,
                   cif2.decrement_counter};

    int errors = 0;
    int checks = 0;
    int hit_n = 0, miss_n = 0, wb_n = 0;
    step_t script[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] sat2(input int n);
        return (n > 3) ? 32'd3 : n;
    endfunction

    // CPU must hold req_valid until the request is fulfilled.
    logic pending = 1'b0;
    always @(negedge clk) begin
        if (reset) pending <= 1'b0;
        else begin
            assert (!(pending && !req_valid))
                else $error("FAIL req_valid_drop: request withdrawn before fulfilment");
            pending <= req_valid && !req_fulfilled;
        end
    end

    function automatic in_t junk();
        in_t i;
        i = $urandom;
        return i;
    endfunction

    task automatic push_words(input bit wb, input int gap_mode);
        step_t s;
        for (int w = 0; w < 4; w++) begin
            int gaps = (gap_mode < 0) ? $urandom_range(0, 3) : gap_mode;
            for (int g = 0; g < gaps; g++) begin
                s = '0;
                s.i = junk(); s.i.rv = 1'b1; s.i.op = script[$].i.op; s.i.hful = 1'b0;
                s.o.mrm = 1'b1; s.o.hreq = 1'b1; s.o.hop = wb;
                script.push_back(s);
            end
            s = '0;
            s.i = junk(); s.i.rv = 1'b1; s.i.op = script[$].i.op;
            s.i.hful = 1'b1; s.i.cd = (w == 3);
            s.o.mrm = 1'b1; s.o.hreq = 1'b1; s.o.hop = wb;
            s.o.dec = (w != 3);
            if (wb && w == 3) begin
                s.o.clr_dirty = 1'b1; s.o.clr_valid = 1'b1;
                s.o.set_addr = 1'b1; s.o.reset_cnt = 1'b1; s.inc_wb = 1'b1;
            end
            if (!wb) s.o.pw = 1'b1;
            script.push_back(s);
        end
    endtask

    // kind: 0 = hit, 1 = clean/invalid-victim miss, 2 = dirty-victim miss.
    task automatic build_txn(input bit op, input int kind, input int gap_mode);
        step_t s;
        s = '0; s.i = junk(); s.i.rv = 1'b1; s.i.op = op;
        script.push_back(s);
        s = '0; s.i = junk(); s.i.rv = 1'b1; s.i.op = op;
        s.i.match = (kind == 0); s.i.dirty = (kind == 2);
        if (kind == 0) begin
            s.o.fulfilled = 1'b1; s.o.lru = 1'b1; s.o.set_dirty = op; s.o.pw = op;
            s.inc_hit = 1'b1;
        end else begin
            s.o.set_addr = 1'b1; s.o.reset_cnt = 1'b1; s.o.mrm = 1'b1; s.inc_miss = 1'b1;
            if (kind == 2) s.o.use_victim = 1'b1;
            else           s.o.clr_valid = 1'b1;
        end
        script.push_back(s);
        if (kind == 0) return;
        if (kind == 2) push_words(1'b1, gap_mode);
        push_words(1'b0, gap_mode);
        s = '0; s.i = junk(); s.i.rv = 1'b1; s.i.op = op;
        s.o.finish = 1'b1; s.o.mrm = 1'b1;
        script.push_back(s);
        s = '0; s.i = junk(); s.i.rv = 1'b1; s.i.op = op; s.i.match = 1'b1;
        s.o.fulfilled = 1'b1; s.o.lru = 1'b1; s.o.set_dirty = op; s.o.pw = op;
        script.push_back(s);
    endtask

    task automatic build_idle(input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s = '0; s.i = junk(); s.i.rv = 1'b0;
            script.push_back(s);
        end
    endtask

    task automatic drive(input in_t i);
        req_valid              = i.rv;
        req_op                 = i.op;
        hmem_req_fulfilled     = i.hful;
        cif.counter_done       = i.cd;
        cif.valid_block_match  = i.match;
        cif.valid_dirty_bit    = i.dirty;
    endtask

    task automatic check_stats();
        check("hit_count",   hit_count,   hit_n);
        check("miss_count",  miss_count,  miss_n);
        check("wb_count",    wb_count,    wb_n);
        check("hit_count2",  {30'd0, hit_count2},  sat2(hit_n));
        check("miss_count2", {30'd0, miss_count2}, sat2(miss_n));
        check("wb_count2",   {30'd0, wb_count2},   sat2(wb_n));
    endtask

    // Plays up to limit steps (limit < 0: whole script); comparison happens mid-cycle.
    task automatic play(input int limit);
        step_t s;
        int n = 0;
        while (script.size() > 0 && (limit < 0 || n < limit)) begin
            s = script.pop_front();
            @(posedge clk); #1;
            drive(s.i);
            @(negedge clk);
            check("outputs",       32'(act),  32'(s.o));
            check("outputs_small", 32'(act2), 32'(s.o));
            check_stats();
            if (s.inc_hit)  hit_n++;
            if (s.inc_miss) miss_n++;
            if (s.inc_wb)   wb_n++;
            n++;
        end
    endtask

    task automatic pin_stats(input int h, input int m, input int w);
        @(posedge clk); #1;
        drive('0);
        @(negedge clk);
        check("idle_outputs", 32'(act), 32'd0);
        check("pin_hit",  hit_count,  h);
        check("pin_miss", miss_count, m);
        check("pin_wb",   wb_count,   w);
    endtask

    initial begin
        drive('0);
        #1;
        check("reset_outputs", 32'(act), 32'd0);
        check_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        build_txn(1'b0, 0, 0); play(-1); pin_stats(1, 0, 0);
        build_txn(1'b1, 0, 0); play(-1); pin_stats(2, 0, 0);
        build_txn(1'b0, 1, 0); play(-1); pin_stats(2, 1, 0);
        build_txn(1'b1, 2, 2); play(-1); pin_stats(2, 2, 1);
        for (int k = 0; k < 3; k++) build_txn(k[0], 0, 0);
        play(-1);
        pin_stats(5, 2, 1);
        check("small_hit_saturated", {30'd0, hit_count2}, 32'd3);

        for (int t = 0; t < 60; t++) begin
            build_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
            build_idle(int'($urandom_range(0, 2)));
        end
        play(-1);

        // Abandon a dirty miss while words are still being written back.
        build_txn(1'b1, 2, 2);
        play(4);
        script.delete();
        check("in_writeback_hreq", 32'(hmem_req_valid), 32'd1);
        reset = 1'b1;
        drive('0);
        #1;
        check("mid_wb_reset_outputs", 32'(act), 32'd0);
        hit_n = 0; miss_n = 0; wb_n = 0;
        check_stats();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_outputs", 32'(act), 32'd0);
        check_stats();
        build_txn(1'b0, 0, 0); play(-1); pin_stats(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
